// File: rtl/grid_cursor_ar.sv
// Keypad-grid cursor: tracks (x,y) over a COLS x ROWS grid with one-hot
// button stepping, press-and-hold auto-repeat, wrap/saturate edges and a
// forbidden-cell mask that is skipped during motion and forces relocation.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   dir_up/down/
//   dir_left/right    debounced direction buttons
//   restriction       enables forbidden-mask enforcement
//   forbidden_mask    bit (y*COLS+x) = 1 marks that cell forbidden
//   pos_x, pos_y      registered cursor column / row
//   val               linear key code pos_y*COLS+pos_x
//   moved             one-cycle pulse after any position change
module grid_cursor_ar #(
    parameter int COLS         = 6,
    parameter int ROWS         = 4,
    parameter int WRAP         = 1,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dir_up,
    input  logic                          dir_down,
    input  logic                          dir_left,
    input  logic                          dir_right,
    input  logic                          restriction,
    input  logic [COLS*ROWS-1:0]          forbidden_mask,
    output logic [$clog2(COLS)-1:0]       pos_x,
    output logic [$clog2(ROWS)-1:0]       pos_y,
    output logic [$clog2(COLS*ROWS)-1:0]  val,
    output logic                          moved
);

    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS*ROWS);
    localparam int XMAX = COLS - 1;
    localparam int YMAX = ROWS - 1;
    localparam int MAXS = ((COLS > ROWS) ? COLS : ROWS) - 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                       : REPEAT_RATE;
    localparam int NW   = $clog2(RMAX);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      dir_q, dir_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   pos_x_q, pos_x_d;
    logic [YW-1:0]   pos_y_q, pos_y_d;
    logic            moved_q;

    logic [3:0]      btn;
    logic            req_ok;
    logic            horiz;
    logic            reloc;
    logic            do_step;

    logic [XW-1:0]   sx;
    logic [YW-1:0]   sy;
    logic            step_hit;
    logic            step_blk;
    logic [XW-1:0]   rx;
    logic [YW-1:0]   ry;

    function automatic logic [CW-1:0] cidx(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        return CW'(y) * CW'(COLS) + CW'(x);
    endfunction

    assign btn    = {dir_up, dir_down, dir_left, dir_right};
    assign req_ok = (btn != 4'b0) && ((btn & (btn - 4'd1)) == 4'b0);
    assign horiz  = dir_left | dir_right;
    assign reloc  = restriction && forbidden_mask[cidx(pos_x_q, pos_y_q)];

    // Walk from the current cell in the pressed direction until an
    // allowed cell turns up, the step budget runs out, or (saturating
    // mode) the edge stops the walk.
    always_comb begin : step_search
        sx       = pos_x_q;
        sy       = pos_y_q;
        step_hit = 1'b0;
        step_blk = 1'b0;
        for (int i = 0; i < MAXS; i++) begin
            if (!step_hit && !step_blk &&
                (horiz ? (i < XMAX) : (i < YMAX))) begin
                if (dir_up) begin
                    if (sy == '0) begin
                        if (WRAP != 0) sy = YW'(YMAX);
                        else           step_blk = 1'b1;
                    end else begin
                        sy = sy - YW'(1);
                    end
                end else if (dir_down) begin
                    if (sy == YW'(YMAX)) begin
                        if (WRAP != 0) sy = '0;
                        else           step_blk = 1'b1;
                    end else begin
                        sy = sy + YW'(1);
                    end
                end else if (dir_left) begin
                    if (sx == '0) begin
                        if (WRAP != 0) sx = XW'(XMAX);
                        else           step_blk = 1'b1;
                    end else begin
                        sx = sx - XW'(1);
                    end
                end else begin
                    if (sx == XW'(XMAX)) begin
                        if (WRAP != 0) sx = '0;
                        else           step_blk = 1'b1;
                    end else begin
                        sx = sx + XW'(1);
                    end
                end
                if (!step_blk &&
                    (!restriction || !forbidden_mask[cidx(sx, sy)]))
                    step_hit = 1'b1;
            end
        end
    end

    // Scan from the top index down so the last hit is the lowest
    // allowed cell; an all-forbidden mask leaves (0,0).
    always_comb begin : reloc_search
        rx = '0;
        ry = '0;
        for (int y = ROWS - 1; y >= 0; y--) begin
            for (int x = COLS - 1; x >= 0; x--) begin
                if (!forbidden_mask[cidx(XW'(x), YW'(y))]) begin
                    rx = XW'(x);
                    ry = YW'(y);
                end
            end
        end
    end

    // Relocation freezes the repeat FSM so buttons are ignored that cycle.
    always_comb begin : next_state
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        do_step = 1'b0;
        if (!reloc) begin
            unique case (state_q)
                IDLE: begin
                    if (req_ok) begin
                        do_step = 1'b1;
                        dir_d   = btn;
                        cnt_d   = NW'(REPEAT_DELAY - 1);
                        state_d = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (btn != dir_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        do_step = 1'b1;
                        cnt_d   = NW'(REPEAT_RATE - 1);
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q - NW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (reloc) begin
            pos_x_d = rx;
            pos_y_d = ry;
        end else if (do_step && step_hit) begin
            pos_x_d = sx;
            pos_y_d = sy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= '0;
            cnt_q   <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            moved_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            moved_q <= (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
        end
    end

    assign pos_x = pos_x_q;
    assign pos_y = pos_y_q;
    assign val   = cidx(pos_x_q, pos_y_q);
    assign moved = moved_q;

endmodule

// File: tb/tb_grid_cursor_ar.sv
// Scoreboard bench for grid_cursor_ar: one WRAP=1 and one WRAP=0 instance
// on a 6x4 grid with REPEAT_DELAY=4, REPEAT_RATE=2.
module tb_grid_cursor_ar;

    localparam logic [3:0]  U = 4'b1000;
    localparam logic [3:0]  D = 4'b0100;
    localparam logic [3:0]  L = 4'b0010;
    localparam logic [3:0]  R = 4'b0001;
    localparam logic [23:0] M = 24'h3CC000;

    typedef struct {
        int    cyc;
        int    inst;
        string nm;
        int    x;
        int    y;
        int    v;
        int    m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn  [2];
    logic        rs   [2];
    logic [23:0] mask [2];
    logic [2:0]  px   [2];
    logic [1:0]  py   [2];
    logic [4:0]  pv   [2];
    logic        pm   [2];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grid_cursor_ar #(
        .COLS(6), .ROWS(4), .WRAP(1),
        .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) u_wrap (
        .clk(clk), .rst(rst),
        .dir_up(btn[0][3]), .dir_down(btn[0][2]),
        .dir_left(btn[0][1]), .dir_right(btn[0][0]),
        .restriction(rs[0]), .forbidden_mask(mask[0]),
        .pos_x(px[0]), .pos_y(py[0]), .val(pv[0]), .moved(pm[0])
    );

    grid_cursor_ar #(
        .COLS(6), .ROWS(4), .WRAP(0),
        .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) u_sat (
        .clk(clk), .rst(rst),
        .dir_up(btn[1][3]), .dir_down(btn[1][2]),
        .dir_left(btn[1][1]), .dir_right(btn[1][0]),
        .restriction(rs[1]), .forbidden_mask(mask[1]),
        .pos_x(px[1]), .pos_y(py[1]), .val(pv[1]), .moved(pm[1])
    );

    // Monitor: pop every expectation due at this cycle and compare.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            checks++;
            if (e.cyc != cyc ||
                int'(px[e.inst]) != e.x || int'(py[e.inst]) != e.y ||
                int'(pv[e.inst]) != e.v || int'(pm[e.inst]) != e.m) begin
                errors++;
                $display("FAIL %s inst%0d cyc%0d: got x=%0d y=%0d val=%0d moved=%0d, want x=%0d y=%0d val=%0d moved=%0d (due cyc%0d)",
                         e.nm, e.inst, cyc, px[e.inst], py[e.inst],
                         pv[e.inst], pm[e.inst], e.x, e.y, e.v, e.m, e.cyc);
            end
        end
    end

    // Expect the outputs after the next clock edge.
    task automatic ex(input int inst, input string nm,
                      input int x, input int y, input int m);
        exp_t t;
        t.cyc  = cyc + 1;
        t.inst = inst;
        t.nm   = nm;
        t.x    = x;
        t.y    = y;
        t.v    = y * 6 + x;
        t.m    = m;
        sbq.push_back(t);
    endtask

    task automatic tap(input int inst, input string nm, input logic [3:0] b,
                       input int x, input int y, input int m);
        @(negedge clk);
        btn[inst] = b;
        ex(inst, nm, x, y, m);
        @(negedge clk);
        btn[inst] = 4'b0;
        ex(inst, {nm, "_rel"}, x, y, 0);
    endtask

    int hx [16] = '{1,1,1,1,2,2,3,3,4,4,5,5,0,0,0,0};
    int hm [16] = '{1,0,0,0,1,0,1,0,1,0,1,0,1,0,0,0};
    int ry [7]  = '{1,1,1,2,2,3,3};
    int rm [7]  = '{0,0,0,1,0,1,0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            btn[i]  = 4'b0;
            rs[i]   = 1'b0;
            mask[i] = M;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ex(0, "reset", 0, 0, 0);
        ex(1, "reset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        ex(0, "post_rst", 0, 0, 0);
        ex(1, "post_rst", 0, 0, 0);

        // single press, then an invalid two-button vector
        @(negedge clk);
        btn[0] = R; btn[1] = R;
        ex(0, "right", 1, 0, 1);
        ex(1, "right", 1, 0, 1);
        @(negedge clk);
        btn[0] = 4'b0; btn[1] = 4'b0;
        ex(0, "right_rel", 1, 0, 0);
        ex(1, "right_rel", 1, 0, 0);
        @(negedge clk);
        btn[0] = U | L; btn[1] = U | L;
        ex(0, "up_left", 1, 0, 0);
        ex(1, "up_left", 1, 0, 0);
        @(negedge clk);
        btn[0] = 4'b0; btn[1] = 4'b0;
        ex(0, "up_left_rel", 1, 0, 0);
        ex(1, "up_left_rel", 1, 0, 0);

        // left edge: wrap vs saturate
        @(negedge clk);
        btn[0] = L; btn[1] = L;
        ex(0, "left", 0, 0, 1);
        ex(1, "left", 0, 0, 1);
        @(negedge clk);
        btn[0] = 4'b0; btn[1] = 4'b0;
        ex(0, "left_rel", 0, 0, 0);
        ex(1, "left_rel", 0, 0, 0);
        @(negedge clk);
        btn[0] = L; btn[1] = L;
        ex(0, "left_wrap", 5, 0, 1);
        ex(1, "left_sat", 0, 0, 0);
        @(negedge clk);
        btn[0] = 4'b0; btn[1] = 4'b0;
        ex(0, "left_wrap_rel", 5, 0, 0);
        ex(1, "left_sat_rel", 0, 0, 0);

        // auto-repeat on hold, then release
        tap(0, "right_wrap", R, 0, 0, 1);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            btn[0] = (j < 14) ? R : 4'b0;
            ex(0, "hold_right", hx[j], 0, hm[j]);
        end

        // navigate both to (4,2)
        tap(0, "nav", L, 5, 0, 1);
        tap(0, "nav", L, 4, 0, 1);
        tap(0, "nav", D, 4, 1, 1);
        tap(0, "nav", D, 4, 2, 1);
        for (int j = 1; j <= 4; j++) tap(1, "nav", R, j, 0, 1);
        tap(1, "nav", D, 4, 1, 1);
        tap(1, "nav", D, 4, 2, 1);

        // forbidden-cell skipping
        @(negedge clk);
        rs[0] = 1'b1; rs[1] = 1'b1;
        ex(0, "restrict_on", 4, 2, 0);
        ex(1, "restrict_on", 4, 2, 0);
        tap(0, "skip_left", L, 1, 2, 1);
        tap(1, "skip_left", L, 1, 2, 1);
        tap(0, "skip_down_wrap", D, 1, 0, 1);
        tap(1, "skip_down_sat", D, 1, 2, 0);
        @(negedge clk);
        rs[0] = 1'b0; rs[1] = 1'b0;
        ex(0, "restrict_off", 1, 0, 0);
        ex(1, "restrict_off", 1, 2, 0);

        // relocation off a forbidden cell
        tap(1, "nav", R, 2, 2, 1);
        tap(1, "nav", D, 2, 3, 1);
        @(negedge clk);
        rs[1] = 1'b1; btn[1] = R;
        ex(1, "reloc", 0, 0, 1);
        @(negedge clk);
        btn[1] = 4'b0;
        ex(1, "reloc_next", 0, 0, 0);
        @(negedge clk);
        ex(1, "reloc_idle", 0, 0, 0);
        @(negedge clk);
        mask[1] = '1;
        ex(1, "all_forbidden", 0, 0, 0);
        @(negedge clk);
        ex(1, "all_forbidden2", 0, 0, 0);
        @(negedge clk);
        mask[1] = M; rs[1] = 1'b0;
        ex(1, "unrestrict", 0, 0, 0);

        // reset in the middle of a hold
        @(negedge clk);
        btn[0] = D;
        ex(0, "hold_down", 1, 1, 1);
        @(negedge clk);
        ex(0, "hold_down", 1, 1, 0);
        @(negedge clk);
        ex(0, "hold_down", 1, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        ex(0, "rst_hold", 0, 0, 0);
        ex(1, "rst_hold", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        ex(0, "repress", 0, 1, 1);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            ex(0, "rehold", 0, ry[j], rm[j]);
        end
        @(negedge clk);
        btn[0] = 4'b0;
        ex(0, "rehold_rel", 0, 3, 0);

        for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations pending, want 0",
                     sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_cursor_ar.md
# grid_cursor_ar

Parametrised keypad-grid cursor with auto-repeat, wrap/saturate edge mode and a run-time forbidden-cell mask. It sits between the debounced/synchronised push-button inputs and the calculator key decoder/display overlay. It tracks a cursor over a COLS×ROWS grid and outputs its coordinates and linear key code. Forbidden cells are skipped during motion, and a cursor left on a forbidden cell is relocated.

## Interface
- COLS, 6, grid columns (≥2)
- ROWS, 4, grid rows (≥2)
- WRAP, 1, 1 = wrap at edges; 0 = saturate at edges
- REPEAT_DELAY, 25_000_000, continuous-hold cycles before the first auto-repeat (≥2)
- REPEAT_RATE, 5_000_000, cycles between subsequent auto-repeats (≥1)
- Derived: XW = $clog2(COLS), YW = $clog2(ROWS), CW = $clog2(COLS*ROWS)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dir_up, dir_down, dir_left, dir_right  in  1 each  direction buttons, already debounced and synchronous to clk
- restriction  in  1  enables forbidden-mask enforcement
- forbidden_mask  in  COLS*ROWS  bit i = 1 marks cell i (i = y*COLS + x) as forbidden
- pos_x  out  XW  cursor column (registered)
- pos_y  out  YW  cursor row (registered)
- val  out  CW  pos_y*COLS + pos_x (combinational from the position registers)
- moved  out  1  one-cycle pulse in the cycle after any position change

## Operation
- Buttons form a 4-bit vector {up, down, left, right}. Only a one-hot vector is a valid request. Zero or ≥2 bits set means no request.
- Step semantics:
  - Up: y−1. Down: y+1. Left: x−1. Right: x+1.
  - WRAP=1: y=0 up → ROWS−1; y=ROWS−1 down → 0; x=0 left → COLS−1; x=COLS−1 right → 0.
  - WRAP=0: a step beyond an edge is no move.
- Forbidden skip, when restriction=1:
  - The target advances repeatedly in the requested direction until an allowed cell is found.
  - The search is limited to COLS−1 steps horizontally or ROWS−1 steps vertically.
  - If no allowed cell is found (or, with WRAP=0, the edge is reached first), there is no move.
  - When restriction=0, the mask is ignored.
- Relocation:
  - If restriction=1 and the mask bit of the current cell is 1, the cursor moves to the lowest-index allowed cell.
  - If every cell is forbidden, it moves to (0,0).
  - Button requests are ignored in that cycle.
- Priority: rst > relocation > movement.
- Auto-repeat FSM states: IDLE, HOLD, REPEAT. It holds a latched direction and a down-counter wide enough for the larger of REPEAT_DELAY and REPEAT_RATE.
  - IDLE + valid request: perform a step, latch the direction, load counter = REPEAT_DELAY−1, go to HOLD.
  - HOLD: if the vector ≠ the latched one-hot, go to IDLE with no step. Else decrement; at counter=0, perform a step, load REPEAT_RATE−1, go to REPEAT.
  - REPEAT: same check. At counter=0, perform a step and reload REPEAT_RATE−1.
  - Direction change (e.g. up→down without release): one cycle in IDLE, then a new press.
  - A step that results in no move (blocked) still keeps the FSM in its hold sequence.
- moved = 1 iff the registered position differs from its previous value (step or relocation).

## Timing
- Reset values: pos_x=0, pos_y=0, val=0, moved=0, FSM=IDLE, counter=0.
- Press latency:
  - The request is sampled at edge k (FSM in IDLE). The new position is visible after edge k, and moved is high in the cycle after edge k.
  - With continuous hold, steps occur at edges k, k+REPEAT_DELAY, k+REPEAT_DELAY+REPEAT_RATE, and so on.
- Relocation takes effect at the first edge where restriction=1 and the current cell is forbidden.
- rst mid-hold: the FSM returns to IDLE. A button still held after reset counts as a new press at the first edge with rst=0.
- A mask change takes effect on the next edge's search. There is no pipelining; all search logic is combinational within one cycle.

## Test plan
Use COLS=6, ROWS=4, REPEAT_DELAY=4, REPEAT_RATE=2, and mask bits {14, 15, 18, 19, 20, 21} = 1 unless noted.

1. Reset: rst high 2 cycles with buttons idle → pos=(0,0), val=0, moved=0. Press right for 1 cycle → pos=(1,0), val=1, one moved pulse. Press up and left together → no change.
2. Left at (0,0): with WRAP=1 → (5,0), val=5. With WRAP=0 → stays (0,0) and moved stays 0.
3. Hold right from (0,0), WRAP=1, restriction=0, press sampled at edge k: x=1 at k, 2 at k+4, 3 at k+6, 4 at k+8, 5 at k+10, 0 at k+12. Release → no further moves.
4. Skip, restriction=1:
   - At (4,2), press left → (1,2), val=13 (cells 15 and 14 skipped).
   - At (1,2), press down, WRAP=1 → (1,0) (cell 19 skipped).
   - At (1,2), press down, WRAP=0 → stays (1,2).
5. Relocation: restriction=0, cursor at (2,3) (val=20). Raise restriction → next edge pos=(0,0) with a moved pulse, and a simultaneous right press is ignored that cycle. With an all-ones mask → (0,0) and no pulse.
6. Hold down for 3 cycles, then assert rst for 1 cycle while still holding → pos=(0,0), FSM=IDLE. The next edge steps to (0,1) and the repeat timing restarts from that edge.
